// File: rtl/fsm_rise_detect_pkg.sv
// Shared types and constants for the rising-edge detector FSM.
package fsm_rise_detect_pkg;

    // Two-bit state code; 2'b11 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b10
    } state_t;

    // Unused encoding, named so checks can refer to it.
    localparam logic [1:0] S_ILLEGAL = 2'b11;

endpackage

// File: rtl/fsm_rise_detect.sv
// Moore rising-edge detector: one-cycle pulse on z per 0->1 run of w.
module fsm_rise_detect
    import fsm_rise_detect_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       w,
    output logic       z,
    output logic [1:0] state
);

    state_t state_q;
    state_t state_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused code falls to S_IDLE via default.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = w ? S_RISE : S_IDLE;
            S_RISE:  state_d = w ? S_HIGH : S_IDLE;
            S_HIGH:  state_d = w ? S_HIGH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register only, so w never reaches z directly.
    assign z     = (state_q == S_RISE);
    assign state = state_q;

    // The pulse is one cycle wide: S_RISE can never follow itself.
    a_z_single: assert property (@(posedge clk) disable iff (!rst_n) z |=> !z);

    // The transition logic never produces the unused code on its own.
    a_no_illegal: assert property (@(posedge clk) disable iff (!rst_n)
                                   state_d != S_ILLEGAL);

endmodule

// File: tb/tb_fsm_rise_detect.sv
// Directed bench for fsm_rise_detect: vector table plus corner sequences.
module tb_fsm_rise_detect;
    import fsm_rise_detect_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       w;
    logic       z;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic   rst_n;
        logic   w;
        state_t st;
        logic   z;
        string  name;
    } vec_t;

    vec_t vq[$];

    fsm_rise_detect dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w     (w),
        .z     (z),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_state(input string name, input logic [1:0] exp);
        checks++;
        if (state !== exp) begin
            errors++;
            $display("FAIL %s state: got %b expected %b", name, state, exp);
        end
    endtask

    task automatic chk_z(input string name, input logic exp);
        checks++;
        if (z !== exp) begin
            errors++;
            $display("FAIL %s z: got %b expected %b", name, z, exp);
        end
    endtask

    // Drive inputs at negedge, clock them in, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic wi, input state_t exp_st,
                        input logic exp_z, input string name);
        @(negedge clk);
        rst_n = r;
        w     = wi;
        @(posedge clk);
        #1;
        chk_state(name, exp_st);
        chk_z(name, exp_z);
    endtask

    initial begin
        int zc;
        rst_n = 1'b0;
        w     = 1'b0;

        // Reset held with w high, then released with w still high.
        vq.push_back('{1'b0, 1'b1, S_IDLE, 1'b0, "rst0"});
        vq.push_back('{1'b0, 1'b1, S_IDLE, 1'b0, "rst1"});
        vq.push_back('{1'b1, 1'b1, S_RISE, 1'b1, "rel_rise"});
        vq.push_back('{1'b1, 1'b1, S_HIGH, 1'b0, "rel_high"});
        vq.push_back('{1'b1, 1'b0, S_IDLE, 1'b0, "to_idle"});
        // Full transition walk.
        vq.push_back('{1'b1, 1'b0, S_IDLE, 1'b0, "walk0"});
        vq.push_back('{1'b1, 1'b1, S_RISE, 1'b1, "walk1"});
        vq.push_back('{1'b1, 1'b0, S_IDLE, 1'b0, "walk2"});
        vq.push_back('{1'b1, 1'b1, S_RISE, 1'b1, "walk3"});
        vq.push_back('{1'b1, 1'b1, S_HIGH, 1'b0, "walk4"});
        vq.push_back('{1'b1, 1'b1, S_HIGH, 1'b0, "walk5"});
        vq.push_back('{1'b1, 1'b1, S_HIGH, 1'b0, "walk6"});
        vq.push_back('{1'b1, 1'b1, S_HIGH, 1'b0, "walk7"});
        vq.push_back('{1'b1, 1'b0, S_IDLE, 1'b0, "walk8"});
        vq.push_back('{1'b1, 1'b0, S_IDLE, 1'b0, "walk9"});
        // Alternating input.
        vq.push_back('{1'b1, 1'b1, S_RISE, 1'b1, "alt0"});
        vq.push_back('{1'b1, 1'b0, S_IDLE, 1'b0, "alt1"});
        vq.push_back('{1'b1, 1'b1, S_RISE, 1'b1, "alt2"});
        vq.push_back('{1'b1, 1'b0, S_IDLE, 1'b0, "alt3"});
        vq.push_back('{1'b1, 1'b1, S_RISE, 1'b1, "alt4"});
        vq.push_back('{1'b1, 1'b0, S_IDLE, 1'b0, "alt5"});

        foreach (vq[i]) step(vq[i].rst_n, vq[i].w, vq[i].st, vq[i].z, vq[i].name);

        // Long high: exactly one pulse over 20 edges.
        zc = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) step(1'b1, 1'b1, S_RISE, 1'b1, "long_first");
            else        step(1'b1, 1'b1, S_HIGH, 1'b0, "long_hold");
            if (z === 1'b1) zc++;
        end
        checks++;
        if (zc != 1) begin
            errors++;
            $display("FAIL long_count pulses: got %0d expected 1", zc);
        end
        step(1'b1, 1'b0, S_IDLE, 1'b0, "long_end");

        // Reset in the middle of a pulse; held level counts as a new rise.
        step(1'b1, 1'b1, S_RISE, 1'b1, "mid_rise");
        step(1'b0, 1'b1, S_IDLE, 1'b0, "mid_rst");
        step(1'b1, 1'b1, S_RISE, 1'b1, "mid_rel");
        step(1'b1, 1'b0, S_IDLE, 1'b0, "mid_idle");

        // Unused code recovers to S_IDLE whatever w is.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            force dut.state_q = state_t'(S_ILLEGAL);
            w = (k == 1);
            #1;
            chk_z(k == 0 ? "ill_w0_z" : "ill_w1_z", 1'b0);
            release dut.state_q;
            @(posedge clk);
            #1;
            chk_state(k == 0 ? "ill_w0_next" : "ill_w1_next", S_IDLE);
            chk_z(k == 0 ? "ill_w0_next" : "ill_w1_next", 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
